// File: rtl/ts_sync_framer_pkg.sv
// ts_pkg: shared definitions for the MPEG-TS sync framer.
//   ts_state_t   : framer state encoding (HUNT/VERIFY/LOCKED), matches the STATE port
//   TS_SYNC_BYTE : default sync byte value
//   TS_PKT_LEN   : default bytes per TS packet
//   SOP_BIT/EOP_BIT : flag positions inside the 10-bit output word
//   TS_CNT_W     : width of the packet / sync-error counters
package ts_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } ts_state_t;

  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
  localparam int unsigned TS_PKT_LEN   = 188;
  localparam int unsigned TS_LOCK_CNT  = 3;
  localparam int unsigned TS_LOSS_CNT  = 3;
  localparam int unsigned SOP_BIT      = 9;
  localparam int unsigned EOP_BIT      = 8;
  localparam int unsigned TS_CNT_W     = 16;

endpackage

// File: rtl/ts_framer_stats.sv
// ts_framer_stats: statistics counters for the TS sync framer.
//   clk            in  clock
//   rst            in  synchronous active-high reset
//   eop_pulse      in  an EOP word is being registered this cycle
//   sync_err_pulse in  a bad sync byte was accepted while locked
//   pkt_count      out packets emitted, wraps
//   sync_err_count out bad syncs while locked, saturates at all-ones
module ts_framer_stats
  import ts_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                eop_pulse,
  input  logic                sync_err_pulse,
  output logic [TS_CNT_W-1:0] pkt_count,
  output logic [TS_CNT_W-1:0] sync_err_count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count      <= '0;
      sync_err_count <= '0;
    end else begin
      if (eop_pulse)
        pkt_count <= pkt_count + 1'b1;
      if (sync_err_pulse && (sync_err_count != '1))
        sync_err_count <= sync_err_count + 1'b1;
    end
  end

endmodule

// File: rtl/ts_sync_framer.sv
// ts_sync_framer: hunts for and verifies TS sync at PKT_LEN spacing; once locked,
// emits every accepted byte as a registered 10-bit word {SOP,EOP,byte}.
//   CLOCK          in   clock
//   RESET          in   synchronous active-high reset
//   TS_DATA        in   TS byte
//   TS_VALID       in   TS_DATA valid this cycle
//   DATA_OUT       out  [9]=SOP [8]=EOP [7:0]=byte
//   WRITE_OUT      out  DATA_OUT valid strobe, one cycle per emitted byte
//   STATE          out  0=HUNT 1=VERIFY 2=LOCKED
//   LOCK           out  STATE==LOCKED
//   PKT_COUNT      out  packets emitted (wraps)
//   SYNC_ERR_COUNT out  bad syncs while locked (saturates)
// Build option: define TS_FRAMER_STATS_EN to enable the counters; otherwise
// PKT_COUNT and SYNC_ERR_COUNT are tied to zero.
module ts_sync_framer
  import ts_pkg::*;
#(
  parameter int unsigned PKT_LEN   = TS_PKT_LEN,
  parameter logic [7:0]  SYNC_BYTE = TS_SYNC_BYTE,
  parameter int unsigned LOCK_CNT  = TS_LOCK_CNT,
  parameter int unsigned LOSS_CNT  = TS_LOSS_CNT
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic [7:0]          TS_DATA,
  input  logic                TS_VALID,
  output logic [9:0]          DATA_OUT,
  output logic                WRITE_OUT,
  output logic [1:0]          STATE,
  output logic                LOCK,
  output logic [TS_CNT_W-1:0] PKT_COUNT,
  output logic [TS_CNT_W-1:0] SYNC_ERR_COUNT
);

  localparam int unsigned IW = $clog2(PKT_LEN);
  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned MW = $clog2(LOSS_CNT + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(PKT_LEN - 1);
  localparam logic [GW-1:0] GOOD_TGT = GW'(LOCK_CNT);
  localparam logic [MW-1:0] MISS_TGT = MW'(LOSS_CNT);

  ts_state_t     state, state_n;
  logic [IW-1:0] idx, idx_n, idx_inc;
  logic [GW-1:0] good, good_n;
  logic [MW-1:0] miss, miss_n;
  logic          match, at_sop, at_eop, emit;
  logic [9:0]    word;

  assign match   = (TS_DATA == SYNC_BYTE);
  assign at_sop  = (idx == '0);
  assign at_eop  = (idx == IDX_LAST);
  assign idx_inc = at_eop ? '0 : idx + 1'b1;

  always_comb begin
    word          = '0;
    word[SOP_BIT] = at_sop;
    word[EOP_BIT] = at_eop;
    word[7:0]     = TS_DATA;
  end

  // idx is held at 0 throughout HUNT, so a sync found there lines up as SOP.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    good_n  = good;
    miss_n  = miss;
    emit    = 1'b0;
    if (TS_VALID) begin
      case (state)
        HUNT: begin
          if (match) begin
            good_n  = GW'(1);
            idx_n   = IW'(1);
            state_n = (LOCK_CNT == 1) ? LOCKED : VERIFY;
            emit    = (LOCK_CNT == 1);
          end
        end
        VERIFY: begin
          idx_n = idx_inc;
          if (at_sop) begin
            if (match) begin
              good_n = good + 1'b1;
              if (good + 1'b1 == GOOD_TGT) begin
                state_n = LOCKED;
                miss_n  = '0;
                emit    = 1'b1;
              end
            end else begin
              state_n = HUNT;
              good_n  = '0;
              idx_n   = '0;
            end
          end
        end
        LOCKED: begin
          idx_n = idx_inc;
          emit  = 1'b1;
          if (at_sop) begin
            if (match) begin
              miss_n = '0;
            end else if (miss + 1'b1 == MISS_TGT) begin
              emit    = 1'b0;
              state_n = HUNT;
              good_n  = '0;
              miss_n  = '0;
              idx_n   = '0;
            end else begin
              miss_n = miss + 1'b1;
            end
          end
        end
        default: begin
          state_n = HUNT;
          idx_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= HUNT;
      idx       <= '0;
      good      <= '0;
      miss      <= '0;
      DATA_OUT  <= '0;
      WRITE_OUT <= 1'b0;
      LOCK      <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      good      <= good_n;
      miss      <= miss_n;
      WRITE_OUT <= emit;
      LOCK      <= (state_n == LOCKED);
      if (emit)
        DATA_OUT <= word;
    end
  end

  assign STATE = state;

`ifdef TS_FRAMER_STATS_EN
  logic eop_pulse, sync_err_pulse;

  assign eop_pulse      = emit & at_eop;
  assign sync_err_pulse = TS_VALID && (state == LOCKED) && at_sop && !match;

  ts_framer_stats u_stats (
    .clk            (CLOCK),
    .rst            (RESET),
    .eop_pulse      (eop_pulse),
    .sync_err_pulse (sync_err_pulse),
    .pkt_count      (PKT_COUNT),
    .sync_err_count (SYNC_ERR_COUNT)
  );
`else
  assign PKT_COUNT      = '0;
  assign SYNC_ERR_COUNT = '0;
`endif

endmodule
